// File: rtl/line_burst_responder_if.sv
// Line-request and memory-burst signals shared by line_burst_responder and its requester.
// The responder connects through the slave modport; the driving side uses master.
interface line_burst_responder_if;
    logic         read_i;
    logic         write_i;
    logic [31:0]  address_i;
    logic [31:0]  mem_byte_en_i;
    logic [255:0] data_i;
    logic         resp_o;
    logic [255:0] data_o;
    logic [31:0]  pmem_address_o;
    logic         pmem_read_o;
    logic         pmem_write_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic         pmem_resp_i;

    modport slave (
        input  read_i, write_i, address_i, mem_byte_en_i, data_i, burst_i, pmem_resp_i,
        output resp_o, data_o, pmem_address_o, pmem_read_o, pmem_write_o, burst_o
    );

    modport master (
        output read_i, write_i, address_i, mem_byte_en_i, data_i, burst_i, pmem_resp_i,
        input  resp_o, data_o, pmem_address_o, pmem_read_o, pmem_write_o, burst_o
    );
endinterface

// File: rtl/line_burst_responder.sv
// Converts 256-bit line reads/writes into four 64-bit memory beats, least significant first.
// Define LINE_BYTE_MERGE_EN to add a read-modify-write pass for partially enabled writes.
module line_burst_responder (
    input  logic                  clk,
    input  logic                  reset_n,
    line_burst_responder_if.slave bus
);
`ifdef LINE_BYTE_MERGE_EN
    typedef enum logic [2:0] {IDLE, RD_BURST, WR_BURST, RESP, RMW_RD} state_t;
`else
    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RESP} state_t;
`endif

    state_t        state_reg;
    state_t        state_next;
    logic [1:0]    cnt_reg;
    logic [255:0]  line_reg;
    logic [31:0]   addr_reg;
    logic          last_beat;
    logic [63:0]   line_beat;
    logic          unused_bits;

    assign last_beat = bus.pmem_resp_i && (cnt_reg == 2'd3);
    assign line_beat = line_reg[{cnt_reg, 6'd0} +: 64];

`ifdef LINE_BYTE_MERGE_EN
    logic [255:0]  wdata_reg;
    logic [31:0]   be_reg;
    logic [63:0]   wdata_beat;
    logic [7:0]    be_beat;
    logic [63:0]   merged_beat;
    logic          full_enable;

    assign wdata_beat  = wdata_reg[{cnt_reg, 6'd0} +: 64];
    assign be_beat     = be_reg[{cnt_reg, 3'd0} +: 8];
    assign full_enable = &bus.mem_byte_en_i;

    // Each memory byte is replaced by the requester's byte only where enabled.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_merge
            assign merged_beat[8*gi +: 8] = be_beat[gi] ? wdata_beat[8*gi +: 8]
                                                        : bus.burst_i[8*gi +: 8];
        end
    endgenerate

    assign unused_bits = &{1'b0, bus.address_i[4:0]};
`else
    assign unused_bits = &{1'b0, bus.address_i[4:0], bus.mem_byte_en_i};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        bus.resp_o         = 1'b0;
        bus.pmem_read_o    = 1'b0;
        bus.pmem_write_o   = 1'b0;
        bus.pmem_address_o = addr_reg;
        bus.burst_o        = 64'd0;
        bus.data_o         = line_reg;
        case (state_reg)
            IDLE: begin
                bus.pmem_address_o = 32'd0;
                if (bus.write_i) begin
`ifdef LINE_BYTE_MERGE_EN
                    state_next = full_enable ? WR_BURST : RMW_RD;
`else
                    state_next = WR_BURST;
`endif
                end else if (bus.read_i) begin
                    state_next = RD_BURST;
                end
            end
            RD_BURST: begin
                bus.pmem_read_o = 1'b1;
                if (last_beat) state_next = RESP;
            end
`ifdef LINE_BYTE_MERGE_EN
            RMW_RD: begin
                bus.pmem_read_o = 1'b1;
                if (last_beat) state_next = WR_BURST;
            end
`endif
            WR_BURST: begin
                bus.pmem_write_o = 1'b1;
                bus.burst_o      = line_beat;
                if (last_beat) state_next = RESP;
            end
            RESP: begin
                bus.resp_o = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: the write line lives in line_reg so a single buffer serves both directions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg   <= 2'd0;
            line_reg  <= 256'd0;
            addr_reg  <= 32'd0;
`ifdef LINE_BYTE_MERGE_EN
            wdata_reg <= 256'd0;
            be_reg    <= 32'd0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= 2'd0;
                    if (bus.write_i) begin
                        addr_reg  <= {bus.address_i[31:5], 5'd0};
                        line_reg  <= bus.data_i;
`ifdef LINE_BYTE_MERGE_EN
                        wdata_reg <= bus.data_i;
                        be_reg    <= bus.mem_byte_en_i;
`endif
                    end else if (bus.read_i) begin
                        addr_reg <= {bus.address_i[31:5], 5'd0};
                    end
                end
                RD_BURST: begin
                    if (bus.pmem_resp_i) begin
                        line_reg[{cnt_reg, 6'd0} +: 64] <= bus.burst_i;
                        cnt_reg <= cnt_reg + 2'd1;
                    end
                end
`ifdef LINE_BYTE_MERGE_EN
                RMW_RD: begin
                    if (bus.pmem_resp_i) begin
                        line_reg[{cnt_reg, 6'd0} +: 64] <= merged_beat;
                        cnt_reg <= cnt_reg + 2'd1;
                    end
                end
`endif
                WR_BURST: begin
                    if (bus.pmem_resp_i) cnt_reg <= cnt_reg + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/line_burst_responder.md
LINE_BURST_RESPONDER -- requirements
Module: line_burst_responder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: read_i  in  1  line read request, held until resp_o.
REQ-004 SHALL have ports: write_i  in  1  line write request, held until resp_o.
REQ-005 SHALL have ports: address_i  in  32  byte address; bits [4:0] ignored.
REQ-006 SHALL have ports: mem_byte_en_i  in  32  per-byte write enable; bit n covers data_i[8n+7:8n].
REQ-007 SHALL have ports: data_i  in  256  write line.
REQ-008 SHALL have ports: resp_o  out  1  one-cycle completion pulse.
REQ-009 SHALL have ports: data_o  out  256  read line, valid while resp_o is high.
REQ-010 SHALL have ports: pmem_address_o  out  32  line address, {address_i[31:5],5'b0}.
REQ-011 SHALL have ports: pmem_read_o  out  1  burst read request; pmem_write_o  out  1  burst write request.
REQ-012 SHALL have ports: burst_i  in  64  read beat; burst_o  out  64  write beat; pmem_resp_i  in  1  beat accept/valid.

Function
REQ-013 SHALL implement states IDLE, RD_BURST, WR_BURST, RESP (plus RMW_RD per REQ-027).
REQ-014 IDLE: write_i high -> latch address, data_i, mem_byte_en_i, go WR_BURST; else read_i high -> latch address, go RD_BURST; else stay.
REQ-015 read_i and write_i high together SHALL be serviced as a write; no read performed.
REQ-016 Latching SHALL occur on the IDLE edge; pmem_read_o/pmem_write_o SHALL rise the cycle after acceptance and stay high until the 4th accepted beat.
REQ-017 A 2-bit beat counter SHALL start at 0, increment only on cycles with pmem_resp_i high, and the 4th beat (count 3) SHALL exit the burst state.
REQ-018 Beat k SHALL map to line bits [64k+63:64k] (beat 0 = least significant) for both directions.
REQ-019 RD_BURST: burst_i SHALL be captured into line buffer slice k on each pmem_resp_i cycle; wait cycles (pmem_resp_i low) SHALL hold counter and buffer.
REQ-020 WR_BURST: burst_o SHALL present slice k of the write buffer combinationally from the counter; slice advances only after pmem_resp_i.
REQ-021 RESP: resp_o high exactly one cycle, data_o = line buffer (read) or don't-care-but-stable buffer contents (write); next state IDLE unconditionally.
REQ-022 pmem_address_o SHALL hold the latched aligned address for the whole transaction, 0 in IDLE.
REQ-023 Minimum read latency: accept at cycle T, 4 zero-wait beats T+1..T+4, resp_o at T+5.
REQ-024 pmem_resp_i outside a burst state SHALL be ignored; upstream requests outside IDLE SHALL be ignored (not queued).
REQ-025 A request still high in the IDLE cycle after RESP SHALL be treated as a new request.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, counter 0, line buffer, address, byte-enable registers to 0; resp_o, pmem_read_o, pmem_write_o, pmem_address_o, burst_o, data_o = 0; in-flight burst abandoned, no resp_o after reset release.

Configuration
REQ-027 Macro LINE_BYTE_MERGE_EN defined: write with mem_byte_en_i != 32'hFFFFFFFF SHALL first enter RMW_RD (4-beat read into buffer, pmem_read_o high), merging only enabled bytes from latched data_i, then WR_BURST of merged line; full-enable writes skip RMW_RD.
REQ-028 LINE_BYTE_MERGE_EN undefined: mem_byte_en_i SHALL be ignored and every write sends data_i unmodified; RMW_RD state absent.

Verification
REQ-029 Read 0x0000_1234, burst_i 0x11..,0x22..,0x33..,0x44.. zero-wait -> pmem_address_o 0x0000_1220, resp_o at T+5, data_o = {0x44..,0x33..,0x22..,0x11..}.
REQ-030 Write data_i = 256'h0..0_4..4_3..3_2..2_1..1, full enables, pmem_resp_i low 2 cycles before beat 2 -> burst_o sequence 1..1,2..2(held),3..3,4..4; one resp_o.
REQ-031 read_i and write_i both high in IDLE -> pmem_write_o asserted, pmem_read_o never asserted.
REQ-032 reset_n low after beat 1 of read -> all outputs 0 same cycle; after release with no request, resp_o stays 0.
REQ-033 LINE_BYTE_MERGE_EN, mem byte-en 32'h0000_000F, data_i bytes 0xAA, memory line all 0x55 -> read burst then write burst with beat 0 = 0x55555555_AAAAAAAA, beats 1-3 all 0x55.
